// File: rtl/stream_demux_1to2.sv
`default_nettype none
// ============================================================================
// Module   : stream_demux_1to2
// Brief    : 1-to-2 valid/ready stream demultiplexer, one-entry slot per channel
//            and a wrapping per-channel output handshake counter.
// Revision : 1.0 - initial release
// ============================================================================
module stream_demux_1to2 #(
    parameter int WIDTH = 2,
    parameter int CW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data,
    output logic [CW-1:0]    a_count,
    output logic [CW-1:0]    b_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    slot_state_t      r_a_state;
    slot_state_t      r_b_state;
    slot_state_t      w_a_state_next;
    slot_state_t      w_b_state_next;
    logic [WIDTH-1:0] r_a_data;
    logic [WIDTH-1:0] r_b_data;
    logic [CW-1:0]    r_a_count;
    logic [CW-1:0]    r_b_count;

    logic w_a_avail;
    logic w_b_avail;
    logic w_in_hs;
    logic w_a_load;
    logic w_b_load;
    logic w_a_hs;
    logic w_b_hs;

    assign a_valid = (r_a_state == FULL);
    assign b_valid = (r_b_state == FULL);
    assign a_data  = r_a_data;
    assign b_data  = r_b_data;
    assign a_count = r_a_count;
    assign b_count = r_b_count;

    // A slot can take a word when empty or when it drains on this same edge.
    assign w_a_avail = !a_valid || a_ready;
    assign w_b_avail = !b_valid || b_ready;
    assign in_ready  = !rst && (in_sel ? w_b_avail : w_a_avail);

    assign w_in_hs  = in_valid && in_ready;
    assign w_a_load = w_in_hs && !in_sel;
    assign w_b_load = w_in_hs &&  in_sel;
    assign w_a_hs   = a_valid && a_ready;
    assign w_b_hs   = b_valid && b_ready;

    always_comb begin
        w_a_state_next = r_a_state;
        w_b_state_next = r_b_state;

        case (r_a_state)
            EMPTY:   if (w_a_load) w_a_state_next = FULL;
            FULL:    if (w_a_hs && !w_a_load) w_a_state_next = EMPTY;
            default: w_a_state_next = EMPTY;
        endcase

        case (r_b_state)
            EMPTY:   if (w_b_load) w_b_state_next = FULL;
            FULL:    if (w_b_hs && !w_b_load) w_b_state_next = EMPTY;
            default: w_b_state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_state <= EMPTY;
            r_b_state <= EMPTY;
            r_a_data  <= '0;
            r_b_data  <= '0;
            r_a_count <= '0;
            r_b_count <= '0;
        end else begin
            r_a_state <= w_a_state_next;
            r_b_state <= w_b_state_next;
            if (w_a_load) r_a_data <= in_data;
            if (w_b_load) r_b_data <= in_data;
            // Counters wrap naturally at 2^CW.
            if (w_a_hs) r_a_count <= r_a_count + CW'(1);
            if (w_b_hs) r_b_count <= r_b_count + CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_demux_1to2.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_demux_1to2
// Brief    : Table-driven self-checking bench for stream_demux_1to2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_demux_1to2;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_sel;
    logic [1:0] in_data;
    logic       a_valid, a_ready, b_valid, b_ready;
    logic [1:0] a_data, b_data;
    logic [7:0] a_count, b_count;

    logic       w_in_valid, w_in_ready, w_in_sel;
    logic [1:0] w_in_data;
    logic       w_a_valid, w_a_ready, w_b_valid, w_b_ready;
    logic [1:0] w_a_data, w_b_data;
    logic [1:0] w_a_count, w_b_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_demux_1to2 #(.WIDTH(2), .CW(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
        .a_count(a_count), .b_count(b_count)
    );

    stream_demux_1to2 #(.WIDTH(2), .CW(2)) dut_w (
        .clk(clk), .rst(rst),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data), .in_sel(w_in_sel),
        .a_valid(w_a_valid), .a_ready(w_a_ready), .a_data(w_a_data),
        .b_valid(w_b_valid), .b_ready(w_b_ready), .b_data(w_b_data),
        .a_count(w_a_count), .b_count(w_b_count)
    );

    typedef struct {
        logic       rst, iv, sel;
        logic [1:0] d;
        logic       ar, br;
        logic       ir;
        logic       av;
        logic [1:0] ad;
        logic       bv;
        logic [1:0] bd;
        logic [7:0] ac, bc;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, iv, sel, input logic [1:0] d, input logic ar, br,
                       input logic ir, av, input logic [1:0] ad, input logic bv,
                       input logic [1:0] bd, input logic [7:0] ac, bc);
        vec_t v;
        v.rst = r;  v.iv = iv; v.sel = sel; v.d = d; v.ar = ar; v.br = br;
        v.ir = ir;  v.av = av; v.ad = ad;   v.bv = bv; v.bd = bd; v.ac = ac; v.bc = bc;
        vq.push_back(v);
    endtask

    task automatic apply(input vec_t v, input int idx);
        string t;
        t = $sformatf("v%0d", idx);
        rst = v.rst; in_valid = v.iv; in_sel = v.sel; in_data = v.d;
        a_ready = v.ar; b_ready = v.br;
        #1;
        chk({t, ".in_ready"}, int'(in_ready), int'(v.ir));
        @(posedge clk); #1;
        chk({t, ".a_valid"}, int'(a_valid), int'(v.av));
        chk({t, ".a_data"},  int'(a_data),  int'(v.ad));
        chk({t, ".b_valid"}, int'(b_valid), int'(v.bv));
        chk({t, ".b_data"},  int'(b_data),  int'(v.bd));
        chk({t, ".a_count"}, int'(a_count), int'(v.ac));
        chk({t, ".b_count"}, int'(b_count), int'(v.bc));
    endtask

    initial begin
        //   rst iv sel d     ar br | ir av ad    bv bd    ac bc
        add(1, 1, 0, 2'b11, 1, 1,   0, 0, 2'b00, 0, 2'b00, 0, 0); // reset beats handshake
        add(0, 1, 0, 2'b01, 1, 0,   1, 1, 2'b01, 0, 2'b00, 0, 0); // route to A
        add(0, 0, 1, 2'b00, 1, 0,   1, 0, 2'b01, 0, 2'b00, 1, 0); // A drains, data held
        add(0, 1, 1, 2'b11, 0, 0,   1, 0, 2'b01, 1, 2'b11, 1, 0); // load B, stall
        add(0, 1, 1, 2'b10, 0, 0,   0, 0, 2'b01, 1, 2'b11, 1, 0); // B backpressure
        add(0, 1, 0, 2'b10, 0, 0,   1, 1, 2'b10, 1, 2'b11, 1, 0); // A still accepts
        add(0, 1, 0, 2'b00, 1, 1,   1, 1, 2'b00, 0, 2'b11, 2, 1); // both drain, A reloads
        add(0, 0, 0, 2'b00, 0, 0,   0, 1, 2'b00, 0, 2'b11, 2, 1); // A stalled
        add(0, 1, 1, 2'b01, 0, 0,   1, 1, 2'b00, 1, 2'b01, 2, 1); // B unaffected by A stall
        add(1, 1, 0, 2'b11, 0, 1,   0, 0, 2'b00, 0, 2'b00, 0, 0); // mid-op reset
        add(0, 0, 0, 2'b00, 0, 0,   1, 0, 2'b00, 0, 2'b00, 0, 0);
        add(0, 0, 1, 2'b00, 0, 0,   1, 0, 2'b00, 0, 2'b00, 0, 0);

        rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = 2'b00;
        a_ready = 1'b0; b_ready = 1'b0;
        w_in_valid = 1'b0; w_in_sel = 1'b1; w_in_data = 2'b00;
        w_a_ready = 1'b0; w_b_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

        // Full-throughput stream into A with a_ready held high.
        a_ready = 1'b1; b_ready = 1'b0; in_valid = 1'b1; in_sel = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_data = 2'(k);
            #1;
            chk($sformatf("thru%0d.in_ready", k), int'(in_ready), 1);
            @(posedge clk); #1;
            chk($sformatf("thru%0d.a_valid", k), int'(a_valid), 1);
            chk($sformatf("thru%0d.a_data", k),  int'(a_data),  k);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("thru.a_count", int'(a_count), 4);
        chk("thru.a_valid_end", int'(a_valid), 0);
        chk("thru.b_valid", int'(b_valid), 0);

        // Counter wrap on the CW=2 instance: five B handshakes.
        w_b_ready = 1'b1; w_in_sel = 1'b1; w_in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            w_in_data = 2'(k);
            if (k == 5) w_in_valid = 1'b0;
            @(posedge clk); #1;
            if (k >= 1) chk($sformatf("wrap%0d.b_count", k), int'(w_b_count), k % 4);
        end
        w_b_ready = 1'b0;
        chk("wrap.a_count", int'(w_a_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_demux_1to2.md
STREAM_DEMUX_1TO2 -- requirements
Module: stream_demux_1to2

Interface
REQ-001 Parameter WIDTH, default 2, sets the data word width in bits.
REQ-002 Parameter CW, default 8, sets the width in bits of each per-channel transfer counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 in_valid  input  1  upstream word present.
REQ-006 in_ready  output  1  block can accept the upstream word this cycle.
REQ-007 in_data  input  WIDTH  upstream word.
REQ-008 in_sel  input  1  destination select for the current word: 0 routes to channel A, 1 routes to channel B.
REQ-009 a_valid  output  1  channel A holds a word.
REQ-010 a_ready  input  1  channel A consumer accepts the word.
REQ-011 a_data  output  WIDTH  channel A word.
REQ-012 b_valid, b_ready, b_data  output/input/output  1/1/WIDTH  channel B, identical semantics to channel A.
REQ-013 a_count, b_count  output  CW  completed output handshakes per channel.

Function
REQ-014 Each channel SHALL contain a one-entry output slot with two states: EMPTY (x_valid=0) and FULL (x_valid=1).
REQ-015 An input handshake SHALL occur when in_valid=1 and in_ready=1 in the same cycle.
REQ-016 An output handshake on a channel SHALL occur when x_valid=1 and x_ready=1 in the same cycle.
REQ-017 in_ready SHALL be combinational and equal to the selected slot's availability: if in_sel=0, (!a_valid | a_ready); if in_sel=1, (!b_valid | b_ready).
REQ-018 in_ready SHALL be forced to 0 while rst=1.
REQ-019 On an input handshake, in_data SHALL be loaded into the slot chosen by in_sel at that edge, and the slot's valid flag SHALL be set.
REQ-020 Latency from input handshake to the corresponding x_valid=1 SHALL be exactly 1 cycle.
REQ-021 A word SHALL never appear on the non-selected channel.
REQ-022 A word SHALL never be duplicated or dropped.
REQ-023 Slot transitions: EMPTY->FULL on load; FULL->EMPTY on output handshake with no load; FULL->FULL on output handshake with simultaneous load, and the new word replaces the old one.
REQ-024 While x_valid=1 and x_ready=0, x_data SHALL remain stable and x_valid SHALL remain 1 (no retraction).
REQ-025 When a slot is EMPTY, x_data SHALL hold its last loaded value.
REQ-026 Both channels SHALL drain independently; simultaneous output handshakes on A and B SHALL both complete in the same cycle.
REQ-027 A stalled channel SHALL NOT block input words destined for the other channel.
REQ-028 in_sel and in_data SHALL be sampled only at the input handshake; upstream holds them stable while in_valid=1 and in_ready=0.
REQ-029 x_count SHALL increment by 1 on each output handshake of its channel.
REQ-030 x_count SHALL wrap from 2^CW-1 to 0 with no flag.
REQ-031 x_count SHALL NOT change on input handshakes.

Reset
REQ-032 When rst=1 at a rising edge, all of the following SHALL be cleared: a_valid=0, b_valid=0, a_data=0, b_data=0, a_count=0, b_count=0.
REQ-033 Words held in a slot when reset asserts mid-operation SHALL be discarded without an output handshake and without a count increment.
REQ-034 Reset SHALL take priority over simultaneous input or output handshakes.
REQ-035 On the first cycle after rst deasserts, in_ready SHALL be 1 for either value of in_sel.

Verification
REQ-036 Basic route test (WIDTH=2):
- Stimulus: send 2'b01 with in_sel=0 while a_ready=1.
- Required response: next cycle a_valid=1, a_data=01, b_valid=0; a_count=1 one cycle later.
REQ-037 Backpressure test:
- Stimulus: load 2'b11 into B with b_ready=0, then present a second B word.
- Required response: in_ready=0, b_data stays 11, b_count unchanged.
- Stimulus: present a word with in_sel=0.
- Required response: in_ready=1 and the word appears on A.
REQ-038 Full-throughput test:
- Stimulus: a_ready=1 held continuously; stream 4 words 00,01,10,11 to A on consecutive cycles.
- Required response: a_data shows 00,01,10,11 on consecutive cycles, a_valid stays 1 throughout, and a_count=4.
REQ-039 Simultaneous test:
- Stimulus: with both slots FULL, assert a_ready=1 and b_ready=1 while sending a new word to A.
- Required response: both channels drain, A reloads with the new word, a_count+1 and b_count+1.
REQ-040 Wrap test (CW=2):
- Stimulus: complete 5 handshakes on B.
- Required response: b_count sequence 1,2,3,0,1.
REQ-041 Mid-operation reset test:
- Stimulus: with a_valid=1 and a_ready=0, assert rst for 1 cycle.
- Required response: a_valid=0, a_data=0, counts=0, in_ready=0 during reset and 1 afterwards.
